// File: rtl/dmem_banked.sv
// Banked word-addressed data memory with byte-enable writes, valid/ready
// request handshake, registered read response and a post-reset zero sweep.
module dmem_banked #(
    parameter int DATA_W      = 32,
    parameter int BANK_ADDR_W = 10,
    parameter int NUM_BANKS   = 8,
    localparam int BANK_SEL_W = $clog2(NUM_BANKS),
    localparam int ADDR_W     = BANK_SEL_W + BANK_ADDR_W,
    localparam int BE_W       = DATA_W / 8,
    localparam int DEPTH      = 2 ** BANK_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [BANK_ADDR_W-1:0] IDX_LAST = {BANK_ADDR_W{1'b1}};
    localparam logic [BANK_ADDR_W-1:0] IDX_ONE  = {{(BANK_ADDR_W-1){1'b0}}, 1'b1};

    logic [0:0]             state_r;
    logic [BANK_ADDR_W-1:0] index_r;
    logic                   rsp_valid_r;
    logic [DATA_W-1:0]      rsp_rdata_r;
    logic                   init_done_r;

    logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

    logic [BANK_SEL_W-1:0]  bank_s;
    logic [BANK_ADDR_W-1:0] word_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   wr_en_s;
    logic                   rd_en_s;

    // Address split and handshake decode; a stalled response blocks new requests.
    always_comb begin
        bank_s   = req_addr[ADDR_W-1:BANK_ADDR_W];
        word_s   = req_addr[BANK_ADDR_W-1:0];
        ready_s  = (state_r == ST_RUN) && !(rsp_valid_r && !rsp_ready);
        accept_s = req_valid && ready_s && !reset;
        wr_en_s  = accept_s && req_write;
        rd_en_s  = accept_s && !req_write;
    end

    assign req_ready = ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign init_done = init_done_r;

    // Control FSM: zero sweep over all banks in parallel, then normal operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_INIT;
            index_r     <= {BANK_ADDR_W{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    index_r <= index_r + IDX_ONE;
                    if (index_r == IDX_LAST) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= ST_INIT;
                        init_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r     <= ST_RUN;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    index_r     <= {BANK_ADDR_W{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: sweep writes during INIT, byte-merged writes during RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_INIT) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    mem[b][index_r] <= {DATA_W{1'b0}};
                end
            end else if (wr_en_s) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (req_be[i]) begin
                        mem[bank_s][word_s][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Response register: load on read accept, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else if (rd_en_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= mem[bank_s][word_s];
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

endmodule

// File: tb/tb_dmem_banked.sv
// Self-checking bench for dmem_banked: directed scenarios plus randomized
// traffic against a flat word-array model with an in-order response queue.
module tb_dmem_banked;

    localparam int DEPTH = 1024;
    localparam int WORDS = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        init_done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [WORDS];
    logic [31:0] rsp_q [$];
    int          init_left;

    always #5 clk = ~clk;

    dmem_banked dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of traffic: drive, check ready, advance, update model, check outputs.
    task automatic cycle(input logic v, input logic w, input logic [12:0] a,
                         input logic [31:0] d, input logic [3:0] be, input logic rr);
        logic exp_ready;
        logic acc;
        logic consume;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        rsp_ready = rr;
        #1;
        exp_ready = (init_left == 0) && !((rsp_q.size() != 0) && !rr);
        check_eq("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        acc     = v && exp_ready;
        consume = (rsp_q.size() != 0) && rr;
        @(posedge clk);
        #1;
        if (consume) void'(rsp_q.pop_front());
        if (acc) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
            end else begin
                rsp_q.push_back(model[a]);
            end
        end
        if (init_left > 0) init_left--;
        check_eq("init_done", {31'd0, init_done}, {31'd0, (init_left == 0)});
        check_eq("rsp_valid", {31'd0, rsp_valid}, {31'd0, (rsp_q.size() != 0)});
        if (rsp_q.size() != 0) check_eq("rsp_rdata", rsp_rdata, rsp_q[0]);
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
        rsp_q.delete();
        init_left = DEPTH;
        #1;
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_init_done", {31'd0, init_done}, 32'd0);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic rd(input logic [12:0] a);
        cycle(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
        cycle(1'b1, 1'b1, a, d, be, 1'b1);
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 1'b0, 13'h0, 32'h0, 4'h0, rr);
    endtask

    initial begin
        logic [12:0] a;
        int          bank;
        int          word;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 13'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b1;

        // Reset and zero sweep with requests held pending.
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 13'(i * 7), 32'h0, 4'h0, 1'b1);
        rd(13'h0000);
        rd(13'h1FFF);
        rd(13'h0A55);
        idle(1'b1);

        // Bank decode: top word of each bank, neighbour stays zero.
        for (int k = 0; k < 8; k++) wr(13'((k << 10) | 'h3FF), 32'hA000_0000 + 32'(k), 4'hF);
        for (int k = 0; k < 8; k++) rd(13'((k << 10) | 'h3FF));
        for (int k = 0; k < 8; k++) rd(13'((k << 10) | 'h3FE));
        idle(1'b1);

        // Byte enables, including an all-zero enable.
        wr(13'h0005, 32'h1122_3344, 4'hF);
        wr(13'h0005, 32'hAABB_CCDD, 4'b0101);
        wr(13'h0005, 32'hFFFF_FFFF, 4'b0000);
        rd(13'h0005);
        check_eq("be_merge", model[5], 32'h11BB_33DD);
        idle(1'b1);

        // Back-to-back reads, then the same under backpressure.
        rd(13'h0000);
        rd(13'h0400);
        rd(13'h0800);
        idle(1'b1);
        cycle(1'b1, 1'b0, 13'h0000, 32'h0, 4'h0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 13'h0400, 32'h0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 13'h0400, 32'h0, 4'h0, 1'b1);
        cycle(1'b1, 1'b0, 13'h0800, 32'h0, 4'h0, 1'b1);
        idle(1'b1);

        // Write-then-read hazard.
        wr(13'h1C00, 32'hDEAD_BEEF, 4'hF);
        rd(13'h1C00);
        idle(1'b1);

        // Randomized mixed traffic over a small hot address set.
        for (int i = 0; i < 3000; i++) begin
            bank = $urandom_range(0, 7);
            word = ($urandom_range(0, 9) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 15);
            a    = 13'((bank << 10) | word);
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                  $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 7));
        end
        idle(1'b1);

        // Reset in the middle of a stalled response.
        wr(13'h1C00, 32'hDEAD_BEEF, 4'hF);
        cycle(1'b1, 1'b0, 13'h1C00, 32'h0, 4'h0, 1'b0);
        idle(1'b0);
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        rd(13'h1C00);
        check_eq("post_reset_model", model[13'h1C00], 32'h0);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_banked.md
# dmem_banked

Parametrised banked data memory for the processor data path: a word-addressed store split into `NUM_BANKS` banks of `2^BANK_ADDR_W` words each. The upper address bits select the bank and the lower bits the word within it. It adds several things a flat bank select lacks: byte-enable writes, a valid/ready request handshake, a registered one-cycle read response with backpressure, and a hardware zero-initialisation sweep after reset. It sits between the load/store stage and the data memory banks, replacing hand-instantiated per-chip enables.

## Interface
- `DATA_W`, 32, word width in bits; must be a multiple of 8.
- `BANK_ADDR_W`, 10, word-address bits within a bank (depth `2^BANK_ADDR_W`).
- `NUM_BANKS`, 8, bank count; power of two ≥ 2.
- `BANK_SEL_W`, derived, `log2(NUM_BANKS)`.
- `ADDR_W`, derived, `BANK_SEL_W + BANK_ADDR_W`.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  `ADDR_W`  word address; `[ADDR_W-1:BANK_ADDR_W]` is the bank, `[BANK_ADDR_W-1:0]` is the word.
- `req_wdata`  in  `DATA_W`  write data.
- `req_be`  in  `DATA_W/8`  byte enables; bit i covers bits `[8i+7:8i]`.
- `rsp_valid`  out  1  read data valid.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  `DATA_W`  read data.
- `init_done`  out  1  high once the zero sweep completes.

## Operation
- The FSM has two states, INIT and RUN.
- **Reset.** When `reset` is high at a rising edge:
  - state → INIT, sweep index → 0;
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `init_done`=0.
- **INIT.**
  - Each cycle, write 0 to word `index` in every bank simultaneously, then increment `index`.
  - After the write at index `2^BANK_ADDR_W - 1`, go to RUN and set `init_done`=1.
  - Requests are never accepted during INIT.
- **RUN, request acceptance.**
  - `req_ready = (state==RUN) && !(rsp_valid && !rsp_ready)`.
  - `req_ready` is combinational from the state and the response register.
- **Accepted write.**
  - Bank `req_addr[ADDR_W-1:BANK_ADDR_W]`, word `req_addr[BANK_ADDR_W-1:0]`.
  - Only the bytes with `req_be[i]`=1 are updated; all other bytes and banks are unchanged.
  - A write produces no response.
  - If `req_be`=0, the write is accepted and has no effect.
- **Accepted read.** The response register loads the addressed word and `rsp_valid` is set.
- **Response register.** It holds its value while `rsp_valid && !rsp_ready`.
  - It clears `rsp_valid` on `rsp_ready` when no new read is accepted in the same cycle.
  - If the response is consumed and a new read is accepted in the same cycle, `rsp_valid` stays high with the new data.
- **Write-then-read.** A read accepted the cycle after a write to the same word returns the written data (byte-merged).
- **Reset mid-operation.** Any pending response is dropped and the INIT sweep restarts from index 0. Memory contents become all zero again.

## Timing
- INIT lasts exactly `2^BANK_ADDR_W` cycles, counted from the first edge with `reset` low. With defaults: 1024 cycles.
- `init_done` and `req_ready` go high on the next cycle (cycle 1024 after release).
- Read latency is 1 cycle: a read accepted at edge t gives `rsp_valid`=1 and `rsp_rdata` valid after edge t.
- Write latency is 1 cycle: memory is updated at the accepting edge.
- With `rsp_ready` held at 1, throughput is one request per cycle (reads or writes, any mix).
- When a response is stalled (`rsp_valid && !rsp_ready`), `req_ready`=0 until the edge where `rsp_ready` is seen high.
- `init_done` stays 1 until the next reset.
- `rsp_rdata` holds its last value when `rsp_valid`=0; it is only meaningful when `rsp_valid`=1.

## Test plan
- **Reset/init.** Assert `reset` for 2 cycles, release, hold `req_valid`=1.
  - `req_ready`=0 and `init_done`=0 for 1024 cycles, then both 1.
  - Read of any address returns 0x00000000.
- **Bank decode.** Write 0xA0000000+k to address (k<<10)|0x3FF for k=0..7, then read all eight back.
  - Each returns its own value.
  - Address 0x3FE in each bank still reads 0.
- **Byte enables.** Write 0x11223344 with be=4'hF to address 0x0005, then 0xAABBCCDD with be=4'b0101.
  - Read returns 0x11BB33DD.
- **Back-to-back with backpressure.**
  - Issue reads at 0x0000, 0x0400, 0x0800 on consecutive cycles with `rsp_ready`=1: responses arrive on the three following cycles, in order.
  - Repeat with `rsp_ready`=0 for 3 cycles: `req_ready`=0 and `rsp_rdata` stays stable until `rsp_ready`=1; no response is lost or duplicated.
- **Write-then-read hazard.** Write 0xDEADBEEF to 0x1C00, then read 0x1C00 on the next cycle.
  - Response one cycle later is 0xDEADBEEF.
- **Reset mid-operation.** With `rsp_valid`=1 and a stalled consumer, pulse `reset` for 1 cycle.
  - Next cycle: `rsp_valid`=0 and `req_ready`=0.
  - After 1024 cycles, a read of the previously written 0x1C00 returns 0.
